// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester side and the transmitter side of the round-robin
//   UART transmit arbiter into one interface.
//   master : the arbiter's view (drives ackH/grantH/xmitH/xmitdataH/busyH/errH)
//   slave  : the environment's view (drives reqH/reqdataH/xmitdoneH)
// Signals:
//   reqH      [NREQ]    request level per requester, held until its ackH
//   reqdataH  [8*NREQ]  byte for requester i in bits [8i+7:8i]
//   ackH      [NREQ]    one-cycle pulse when requester i's frame is finished
//   grantH    [NREQ]    one-hot, requester currently being served
//   xmitH               one-cycle transmit strobe to the UART
//   xmitdataH [8]       byte presented to the UART
//   xmitdoneH           UART idle flag (low while a frame is on the wire)
//   busyH               arbiter not idle
//   errH                sticky watchdog abort flag
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   reqH;
    logic [8*NREQ-1:0] reqdataH;
    logic [NREQ-1:0]   ackH;
    logic [NREQ-1:0]   grantH;
    logic              xmitH;
    logic [7:0]        xmitdataH;
    logic              xmitdoneH;
    logic              busyH;
    logic              errH;

    modport master (
        input  reqH, reqdataH, xmitdoneH,
        output ackH, grantH, xmitH, xmitdataH, busyH, errH
    );

    modport slave (
        output reqH, reqdataH, xmitdoneH,
        input  ackH, grantH, xmitH, xmitdataH, busyH, errH
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler sharing one 8-bit UART transmitter among NREQ
//   byte requesters. A winner is picked in IDLE, its byte is latched onto
//   xmitdataH, xmitH is strobed for one cycle, and the transmitter's
//   xmitdoneH handshake is followed (low = frame running, high = done)
//   before the winner receives a one-cycle ackH pulse.
// Ports:
//   sysclk   system clock, rising edge
//   sysrstH  asynchronous active-high reset
//   bus      uart_tx_arbiter_if.master (requester + transmitter signals)
// Parameters:
//   NREQ  number of requesters (2..8)
//   PTRW  round-robin pointer width, >= clog2(NREQ)
//   TOW   watchdog counter width
// Build option:
//   UART_TX_ARB_WATCHDOG_EN  when defined, a TOW-bit watchdog aborts a
//   transfer stuck in WAITBUSY/WAITDONE, still acks the requester and sets
//   the sticky errH flag. When undefined, errH is tied low.
module uart_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int PTRW = 2,
    parameter int TOW  = 12
) (
    input  logic               sysclk,
    input  logic               sysrstH,
    uart_tx_arbiter_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAITBUSY = 3'd2,
        WAITDONE = 3'd3,
        ACK      = 3'd4
    } state_t;

    // Catch bad parameter combinations at elaboration time.
    if (NREQ < 2 || NREQ > 8 || PTRW < $clog2(NREQ) || TOW < 2) begin : g_param_check
        $error("uart_tx_arbiter: illegal NREQ/PTRW/TOW combination");
    end

    state_t            state_reg, state_next;
    logic [PTRW-1:0]   ptr_reg;
    logic [PTRW-1:0]   idx_reg;
    logic [7:0]        xmitdata_reg;

    logic              found;
    logic [PTRW-1:0]   win_idx;
    logic [PTRW-1:0]   ptr_win_next;
    logic [7:0]        win_byte;
    int                cand;

    logic              capture;
    logic              xmit;
    logic              serving;
    logic              ack_en;
    logic              busy;

`ifdef UART_TX_ARB_WATCHDOG_EN
    logic [TOW-1:0]    wdog_reg;
    logic              err_reg;
    logic              wdog_trip;
`endif

    // Round-robin search: ptr, ptr+1, ... wrapping modulo NREQ; first
    // requester found wins. ptr is always kept below NREQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_reg) + k) % NREQ;
            if (!found && bus.reqH[cand]) begin
                found   = 1'b1;
                win_idx = PTRW'(cand);
            end
        end
        ptr_win_next = PTRW'((int'(win_idx) + 1) % NREQ);
        win_byte     = bus.reqdataH[8*int'(win_idx) +: 8];
    end

    // Next-state and output decode. Outputs are decoded from the registered
    // state so an asynchronous reset clears them immediately.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        xmit       = 1'b0;
        serving    = 1'b0;
        ack_en     = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                // The transmitter must report idle before a byte is issued.
                if (found && bus.xmitdoneH) begin
                    capture    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                xmit       = 1'b1;
                serving    = 1'b1;
                state_next = WAITBUSY;
            end
            WAITBUSY: begin
                serving = 1'b1;
                if (!bus.xmitdoneH) state_next = WAITDONE;
            end
            WAITDONE: begin
                serving = 1'b1;
                if (bus.xmitdoneH) state_next = ACK;
            end
            ACK: begin
                ack_en     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
`ifdef UART_TX_ARB_WATCHDOG_EN
        wdog_trip = 1'b0;
        if ((state_reg == WAITBUSY || state_reg == WAITDONE) && (&wdog_reg)) begin
            wdog_trip  = 1'b1;
            state_next = ACK;
        end
`endif
    end

    always_ff @(posedge sysclk or posedge sysrstH) begin
        if (sysrstH) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            idx_reg      <= '0;
            xmitdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            // reqdataH is only sampled here, at the IDLE capture.
            if (capture) begin
                idx_reg      <= win_idx;
                ptr_reg      <= ptr_win_next;
                xmitdata_reg <= win_byte;
            end
        end
    end

`ifdef UART_TX_ARB_WATCHDOG_EN
    always_ff @(posedge sysclk or posedge sysrstH) begin
        if (sysrstH) begin
            wdog_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ISSUE:              wdog_reg <= '0;
                WAITBUSY, WAITDONE: wdog_reg <= wdog_reg + 1'b1;
                default:            wdog_reg <= wdog_reg;
            endcase
            if (wdog_trip) err_reg <= 1'b1;
        end
    end

    assign bus.errH = err_reg;
`else
    assign bus.errH = 1'b0;
`endif

    // Per-requester decode of grant (during the transfer) and ack (ACK only).
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_decode
        assign bus.grantH[gi] = serving && (idx_reg == PTRW'(gi));
        assign bus.ackH[gi]   = ack_en  && (idx_reg == PTRW'(gi));
    end

    assign bus.xmitH     = xmit;
    assign bus.xmitdataH = xmitdata_reg;
    assign bus.busyH     = busy;

endmodule
